// File: rtl/seq_det_frame_ctrl.sv
// seq_det_frame_ctrl
// Frame sequencer for a bit-serial Moore "1111" detector. Parallel words
// arriving over a valid/ready handshake are shifted out MSB-first on
// det_seq_in. The detector's Moore output is sampled one cycle after each
// presented bit, and match cycles are counted per frame with saturation.
// At end of frame the count is offered on res_valid/res_count. After it is
// accepted, the detector is cleared with a one-cycle det_reset pulse.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   upstream word valid
//   in_data    in   WORD_W-bit word, serialised MSB first
//   in_last    in   word closes its frame
//   in_ready   out  word accepted this cycle (state-decoded)
//   det_seq_in out  serial bit to detector sequence_in (registered)
//   det_reset  out  detector reset, active-high (registered)
//   det_out    in   detector detector_out
//   res_valid  out  frame result valid (state-decoded)
//   res_count  out  saturating match-cycle count (registered)
//   res_ready  in   downstream accepts result
//   busy       out  high in any state other than IDLE
module seq_det_frame_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              det_seq_in,
  output logic              det_reset,
  input  logic              det_out,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  input  logic              res_ready,
  output logic              busy
);

  localparam int BC_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(WORD_W);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

  typedef enum logic [2:0] {IDLE, SHIFT, DRAIN, REPORT, CLEAR} state_t;

  state_t              state_q;
  logic [WORD_W-1:0]   sreg_q;
  logic [BC_W-1:0]     bitcnt_q;
  logic                last_q;
  logic                samp_en_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                det_reset_q;
  logic                final_bit;
  logic                xfer;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    final_bit = (state_q == SHIFT) && (bitcnt_q == BC_ONE);
    // In IDLE, hold off while the detector is still in reset. Mid-frame, the
    // next word is accepted on the final bit so that bits stay contiguous.
    in_ready  = ((state_q == IDLE) && !det_reset_q) || (final_bit && !last_q);
    xfer      = in_valid && in_ready;
    res_valid = (state_q == REPORT);
    busy      = (state_q != IDLE);
    count_d   = (samp_en_q && det_out) ? sat_inc(count_q) : count_q;
  end

  // The shift register drains to all zeros by the last bit, so its MSB is
  // already 0 in every state other than SHIFT.
  assign det_seq_in = sreg_q[WORD_W-1];
  assign det_reset  = det_reset_q;
  assign res_count  = count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bitcnt_q    <= '0;
      last_q      <= 1'b0;
      samp_en_q   <= 1'b0;
      count_q     <= '0;
      det_reset_q <= 1'b1;
    end else begin
      // A bit presented this cycle reaches detector_out one edge later.
      samp_en_q   <= (state_q == SHIFT);
      det_reset_q <= 1'b0;
      count_q     <= count_d;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            sreg_q   <= in_data;
            bitcnt_q <= BC_LOAD;
            last_q   <= in_last;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (final_bit && xfer) begin
            sreg_q   <= in_data;
            bitcnt_q <= BC_LOAD;
            last_q   <= in_last;
          end else begin
            sreg_q   <= {sreg_q[WORD_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q - BC_ONE;
            if (final_bit) state_q <= last_q ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          state_q <= REPORT;
        end
        REPORT: begin
          if (res_ready) begin
            state_q     <= CLEAR;
            det_reset_q <= 1'b1;
          end
        end
        CLEAR: begin
          count_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
